dmem_load_store_unit: RTL and testbench

- Executes the data-memory transfer requested by the main control unit's decode outputs: mem write, d_size, d_unsigned, plus a load request.
- Drives a word-addressed req/gnt/rvalid data bus, generates byte enables and lane-replicated store data, and sign/zero-extends load data.
- Stalls the pipeline until the transfer completes. Sits in the MEM stage between the pipeline register and DMEM.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/dmem_load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_dmem_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes, FSM states, lane helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package lsu_pkg;

  // Access size codes, identical to the 2-bit d_size encoding driven by decode
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_t;

  // Byte-lane enables for an access of the given size at the given byte offset
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Natural-alignment check; the reserved size code is treated as misaligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = |addr_lo;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load shift and sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the results are sampled.
module dmem_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_wdata_rep,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  // Store side: the slave picks lanes by byte enable, so the datum is copied into every lane
  always_comb begin
    st_be        = be_for(st_size, st_addr_lo);
    st_wdata_rep = st_wdata;
    case (st_size)
      SIZE_BYTE: st_wdata_rep = {(XLEN/8){st_wdata[7:0]}};
      SIZE_HALF: st_wdata_rep = {(XLEN/16){st_wdata[15:0]}};
      default:   st_wdata_rep = st_wdata;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend to full width
  always_comb begin
    ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_data    = ld_shifted;
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                       : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                       : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      default:   ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_load_store_unit.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid data-bus transfer per decoded load or store.
// Latency: at least 3 stalled cycles (IDLE accept, REQ with gnt, WAIT with rvalid), result strobed in DONE.
// Backpressure: o_stall holds the pipeline while the bus withholds gnt/rvalid; a timeout aborts a dead bus.
module dmem_load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [1:0]      i_d_size,
  input  logic            i_d_unsigned,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rdata_valid,
  output logic            o_misaligned,
  output logic            o_bus_err,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [3:0]      o_bus_be,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_gnt,
  input  logic            i_bus_rvalid,
  input  logic [XLEN-1:0] i_bus_rdata
);

  // Counter just wide enough to reach TIMEOUT_CYCLES; a zero limit never fires
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  lsu_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic            access, misaligned, start;
  logic            timeout_hit, timeout_fire, enter_done;

  logic [1:0]      ld_size_q;
  logic            ld_unsigned_q;
  logic [1:0]      ld_addr_lo_q;

  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata_rep;
  logic [XLEN-1:0] ld_data;

  assign access      = i_mem_read | i_mem_write;
  assign misaligned  = is_misaligned(i_d_size, i_addr[1:0]);
  assign start       = (state_q == ST_IDLE) && access && !misaligned;
  // The count seen in the cycle being evaluated; this cycle is the limit-th one spent waiting
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

  dmem_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .st_size     (i_d_size),
    .st_addr_lo  (i_addr[1:0]),
    .st_wdata    (i_wdata),
    .st_be       (st_be),
    .st_wdata_rep(st_wdata_rep),
    .ld_size     (ld_size_q),
    .ld_unsigned (ld_unsigned_q),
    .ld_addr_lo  (ld_addr_lo_q),
    .ld_rdata    (i_bus_rdata),
    .ld_data     (ld_data)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, stall and misalignment flags; real bus progress beats a coincident timeout
  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    o_stall      = 1'b0;
    o_misaligned = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_misaligned = access && misaligned;
        o_stall      = start;
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        o_stall = 1'b1;
        if (i_bus_gnt) begin
          state_d = ST_WAIT;
        end else if (timeout_hit) begin
          state_d      = ST_DONE;
          timeout_fire = 1'b1;
        end
      end
      ST_WAIT: begin
        o_stall = 1'b1;
        if (i_bus_rvalid) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d      = ST_DONE;
          timeout_fire = 1'b1;
        end
      end
      // Pipeline advances this cycle, so any access still presented belongs to this instruction
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_done = (state_q != ST_DONE) && (state_d == ST_DONE);

  // Wait-cycle counter: runs while a transfer is outstanding, cleared otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                         cnt_q <= '0;
    else if (state_q == ST_REQ || state_q == ST_WAIT)  cnt_q <= cnt_q + CNT_W'(1);
    else                                               cnt_q <= '0;
  end

  // Bus request registers and load attributes; held stable from accept until the next accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_be      <= '0;
      o_bus_wdata   <= '0;
      ld_size_q     <= SIZE_BYTE;
      ld_unsigned_q <= 1'b0;
      ld_addr_lo_q  <= 2'b00;
    end else begin
      if (start) begin
        o_bus_req     <= 1'b1;
        o_bus_we      <= i_mem_write;
        o_bus_addr    <= {i_addr[XLEN-1:2], 2'b00};
        o_bus_be      <= st_be;
        o_bus_wdata   <= st_wdata_rep;
        ld_size_q     <= i_d_size;
        ld_unsigned_q <= i_d_unsigned;
        ld_addr_lo_q  <= i_addr[1:0];
      end else if (state_q == ST_REQ && (i_bus_gnt || timeout_fire)) begin
        o_bus_req <= 1'b0;
      end
    end
  end

  // Result, completion strobe and error flag; stores and aborted accesses return zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_bus_err     <= 1'b0;
    end else begin
      if (timeout_fire) begin
        o_rdata <= '0;
      end else if (state_q == ST_WAIT && i_bus_rvalid) begin
        o_rdata <= o_bus_we ? '0 : ld_data;
      end
      o_rdata_valid <= enter_done;
      o_bus_err     <= timeout_fire;
    end
  end

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Directed bench for the load/store unit with a hand-driven req/gnt/rvalid bus.
// Latency: checks the minimum 3-cycle stall and delayed-grant stalls.
// Backpressure: exercises gnt delay, dead-bus timeout and reset mid-transfer.
module tb_dmem_load_store_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_d_size;
  logic        i_d_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_misaligned;
  logic        o_bus_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_load_store_unit #(
    .XLEN(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_d_size     (i_d_size),
    .i_d_unsigned (i_d_unsigned),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_stall      (o_stall),
    .o_rdata      (o_rdata),
    .o_rdata_valid(o_rdata_valid),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_gnt    (i_bus_gnt),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus transfer with a simple slave: gnt after gnt_delay REQ cycles, rvalid the cycle after gnt
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gnt_delay,
                            output logic [31:0] res, output int stalls,
                            output logic [3:0] be_seen, output logic [31:0] wd_seen,
                            output logic [31:0] addr_seen, output bit done);
    int req_wait;
    bit pend;
    req_wait = 0; pend = 0; stalls = 0; done = 0;
    res = 32'h0; be_seen = 4'h0; wd_seen = 32'h0; addr_seen = 32'h0;
    @(negedge i_clk);
    i_mem_read = !we; i_mem_write = we; i_d_size = size; i_d_unsigned = uns;
    i_addr = addr; i_wdata = wdata; i_bus_rdata = rdata;
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge i_clk);
      #1;
      if (o_rdata_valid) begin
        done = 1;
        res  = o_rdata;
      end else begin
        if (o_stall) stalls++;
        i_bus_rvalid = pend;
        pend = 0;
        if (o_bus_req) begin
          if (req_wait == 0) begin
            be_seen = o_bus_be; wd_seen = o_bus_wdata; addr_seen = o_bus_addr;
          end
          if (req_wait >= gnt_delay) begin
            i_bus_gnt = 1'b1;
            pend = 1;
          end else begin
            i_bus_gnt = 1'b0;
          end
          req_wait++;
        end else begin
          i_bus_gnt = 1'b0;
        end
      end
    end
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0; i_d_size = 2'b00; i_d_unsigned = 1'b0;
    i_addr = 32'h0; i_wdata = 32'h0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0;
    repeat (2) @(negedge i_clk);
    #1;
    n_checks++; if ({o_bus_req, o_bus_we, o_bus_be} !== 6'b0) begin n_fail++; $display("FAIL reset_bus_ctl: got %b required 000000", {o_bus_req, o_bus_we, o_bus_be}); end
    n_checks++; if ({o_bus_addr, o_bus_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_bus_data: got %h required 0", {o_bus_addr, o_bus_wdata}); end
    n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", o_rdata); end
    n_checks++; if ({o_rdata_valid, o_bus_err, o_stall, o_misaligned} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 0000", {o_rdata_valid, o_bus_err, o_stall, o_misaligned}); end
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    n_checks++; if ({o_bus_req, o_stall, o_rdata_valid} !== 3'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b required 000", {o_bus_req, o_stall, o_rdata_valid}); end
  endtask

  task automatic test_load_byte_signed();
    int stalls;
    stalls = 0;
    @(negedge i_clk);
    i_mem_read = 1'b1; i_mem_write = 1'b0; i_d_size = 2'b00; i_d_unsigned = 1'b0;
    i_addr = 32'h1003; i_bus_rdata = 32'h80AABBCC;
    #1; if (o_stall) stalls++;
    n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL lb_misaligned: got %b required 0", o_misaligned); end
    @(negedge i_clk); #1; if (o_stall) stalls++;
    n_checks++; if ({o_bus_req, o_bus_we, o_bus_be} !== 6'b10_1000) begin n_fail++; $display("FAIL lb_req_be: got %b required 101000", {o_bus_req, o_bus_we, o_bus_be}); end
    n_checks++; if (o_bus_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h required 00001000", o_bus_addr); end
    i_bus_gnt = 1'b1;
    @(negedge i_clk); #1; if (o_stall) stalls++;
    n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL lb_req_drop: got %b required 0", o_bus_req); end
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b1;
    @(negedge i_clk); #1; if (o_stall) stalls++;
    i_bus_rvalid = 1'b0;
    n_checks++; if (o_rdata_valid !== 1'b1) begin n_fail++; $display("FAIL lb_valid: got %b required 1", o_rdata_valid); end
    n_checks++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h required ffffff80", o_rdata); end
    // read still presented during DONE must not start a second transfer
    @(negedge i_clk);
    i_mem_read = 1'b0;
    #1;
    n_checks++; if ({o_rdata_valid, o_bus_req} !== 2'b00) begin n_fail++; $display("FAIL lb_after_done: got %b required 00", {o_rdata_valid, o_bus_req}); end
    n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d required 3", stalls); end
  endtask

  task automatic test_store_half_delayed();
    @(negedge i_clk);
    i_mem_read = 1'b0; i_mem_write = 1'b1; i_d_size = 2'b01; i_d_unsigned = 1'b0;
    i_addr = 32'h2002; i_wdata = 32'h1234ABCD;
    #1;
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL sh_stall_idle: got %b required 1", o_stall); end
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk); #1;
      n_checks++; if ({o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCDABCD}) begin n_fail++; $display("FAIL sh_req_hold%0d: got req=%b we=%b be=%b addr=%h wdata=%h required 1 1 1100 00002000 abcdabcd", i, o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata); end
      i_bus_gnt = (i == 4);
    end
    @(negedge i_clk); #1;
    i_bus_gnt = 1'b0;
    n_checks++; if ({o_bus_req, o_rdata_valid, o_stall} !== 3'b001) begin n_fail++; $display("FAIL sh_wait: got req/valid/stall=%b required 001", {o_bus_req, o_rdata_valid, o_stall}); end
    i_bus_rvalid = 1'b1;
    @(negedge i_clk); #1;
    i_bus_rvalid = 1'b0;
    n_checks++; if ({o_rdata_valid, o_bus_err, o_stall} !== 3'b100) begin n_fail++; $display("FAIL sh_done: got valid/err/stall=%b required 100", {o_rdata_valid, o_bus_err, o_stall}); end
    n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL sh_rdata: got %h required 0", o_rdata); end
    @(negedge i_clk);
    i_mem_write = 1'b0;
    #1;
    n_checks++; if (o_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL sh_valid_once: got %b required 0", o_rdata_valid); end
  endtask

  task automatic test_half_extend();
    logic [31:0] res, wd, ad;
    logic [3:0]  be;
    int          st;
    bit          ok;
    run_access(1'b0, 2'b01, 1'b1, 32'h0006, 32'h0, 32'h80010000, 0, res, st, be, wd, ad, ok);
    n_checks++; if (!ok || res !== 32'h00008001) begin n_fail++; $display("FAIL lhu: done=%0d got %h required 00008001", ok, res); end
    n_checks++; if (be !== 4'b1100 || ad !== 32'h4 || st !== 3) begin n_fail++; $display("FAIL lhu_bus: be=%b addr=%h stalls=%0d required 1100 00000004 3", be, ad, st); end
    run_access(1'b0, 2'b01, 1'b0, 32'h0006, 32'h0, 32'h80010000, 0, res, st, be, wd, ad, ok);
    n_checks++; if (!ok || res !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: done=%0d got %h required ffff8001", ok, res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, wd, ad;
    logic [3:0]  be;
    int          st;
    bit          ok;
    run_access(1'b1, 2'b00, 1'b0, 32'h3001, 32'h000000A5, 32'hFFFFFFFF, 1, res, st, be, wd, ad, ok);
    n_checks++; if (!ok || res !== 32'h0 || st !== 4) begin n_fail++; $display("FAIL sb: done=%0d rdata=%h stalls=%0d required 0 4", ok, res, st); end
    n_checks++; if (be !== 4'b0010 || wd !== 32'hA5A5A5A5 || ad !== 32'h3000) begin n_fail++; $display("FAIL sb_bus: be=%b wdata=%h addr=%h required 0010 a5a5a5a5 00003000", be, wd, ad); end
    run_access(1'b0, 2'b00, 1'b1, 32'h3002, 32'h0, 32'h00F70000, 0, res, st, be, wd, ad, ok);
    n_checks++; if (!ok || res !== 32'h000000F7 || be !== 4'b0100) begin n_fail++; $display("FAIL lbu: done=%0d got %h be=%b required 000000f7 0100", ok, res, be); end
    run_access(1'b0, 2'b10, 1'b1, 32'h3004, 32'h0, 32'h92345678, 0, res, st, be, wd, ad, ok);
    n_checks++; if (!ok || res !== 32'h92345678 || be !== 4'b1111) begin n_fail++; $display("FAIL lw: done=%0d got %h be=%b required 92345678 1111", ok, res, be); end
  endtask

  task automatic test_misaligned();
    int reqs;
    reqs = 0;
    @(negedge i_clk);
    i_mem_read = 1'b1; i_mem_write = 1'b0; i_d_size = 2'b10; i_addr = 32'h0005;
    #1;
    n_checks++; if ({o_misaligned, o_stall} !== 2'b10) begin n_fail++; $display("FAIL mis_word: got mis/stall=%b required 10", {o_misaligned, o_stall}); end
    repeat (3) begin @(negedge i_clk); #1; if (o_bus_req) reqs++; end
    i_d_size = 2'b11; i_addr = 32'h0000;
    #1;
    n_checks++; if ({o_misaligned, o_stall} !== 2'b10) begin n_fail++; $display("FAIL mis_size11: got mis/stall=%b required 10", {o_misaligned, o_stall}); end
    repeat (3) begin @(negedge i_clk); #1; if (o_bus_req) reqs++; end
    i_mem_read = 1'b0; i_mem_write = 1'b1; i_d_size = 2'b01; i_addr = 32'h0011;
    #1;
    n_checks++; if ({o_misaligned, o_stall} !== 2'b10) begin n_fail++; $display("FAIL mis_half_store: got mis/stall=%b required 10", {o_misaligned, o_stall}); end
    i_d_size = 2'b00;
    #1;
    n_checks++; if ({o_misaligned, o_stall} !== 2'b01) begin n_fail++; $display("FAIL aligned_odd_byte: got mis/stall=%b required 01", {o_misaligned, o_stall}); end
    i_mem_write = 1'b0;
    repeat (2) begin @(negedge i_clk); #1; if (o_bus_req) reqs++; end
    n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL mis_no_req: got %0d req cycles required 0", reqs); end
  endtask

  task automatic test_timeout();
    int reqs;
    bit seen;
    logic [31:0] res, wd, ad;
    logic [3:0]  be;
    int          st;
    bit          ok;
    reqs = 0; seen = 0;
    @(negedge i_clk);
    i_mem_read = 1'b1; i_d_size = 2'b10; i_d_unsigned = 1'b0; i_addr = 32'h0100; i_bus_gnt = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge i_clk); #1;
      if (o_bus_err) seen = 1;
      else if (o_bus_req) reqs++;
    end
    n_checks++; if (!seen || reqs !== 8) begin n_fail++; $display("FAIL timeout_cycles: err_seen=%0d req_cycles=%0d required 1 8", seen, reqs); end
    n_checks++; if ({o_rdata_valid, o_bus_req, o_stall} !== 3'b100 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_done: valid/req/stall=%b rdata=%h required 100 0", {o_rdata_valid, o_bus_req, o_stall}, o_rdata); end
    i_mem_read = 1'b0;
    @(negedge i_clk); #1;
    n_checks++; if ({o_bus_err, o_rdata_valid} !== 2'b00) begin n_fail++; $display("FAIL timeout_clear: err/valid=%b required 00", {o_bus_err, o_rdata_valid}); end
    run_access(1'b0, 2'b10, 1'b0, 32'h0040, 32'h0, 32'hDEADBEEF, 2, res, st, be, wd, ad, ok);
    n_checks++; if (!ok || res !== 32'hDEADBEEF || o_bus_err !== 1'b0) begin n_fail++; $display("FAIL after_timeout: done=%0d got %h err=%b required deadbeef 0", ok, res, o_bus_err); end
  endtask

  task automatic test_reset_mid_transfer();
    int events;
    events = 0;
    // reset while waiting for rvalid
    @(negedge i_clk);
    i_mem_read = 1'b1; i_d_size = 2'b10; i_addr = 32'h0080; i_bus_rdata = 32'hCAFEF00D;
    @(negedge i_clk); #1;
    i_bus_gnt = 1'b1;
    @(negedge i_clk); #1;
    i_bus_gnt = 1'b0; i_mem_read = 1'b0; i_rst = 1'b1;
    #1;
    n_checks++; if ({o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_rdata} !== 70'h0) begin n_fail++; $display("FAIL rst_wait_outputs: req=%b we=%b be=%b addr=%h rdata=%h required all 0", o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_rdata); end
    n_checks++; if ({o_rdata_valid, o_bus_err, o_stall} !== 3'b000) begin n_fail++; $display("FAIL rst_wait_flags: got %b required 000", {o_rdata_valid, o_bus_err, o_stall}); end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    i_bus_rvalid = 1'b1;
    repeat (3) begin
      @(negedge i_clk); #1;
      i_bus_rvalid = 1'b0;
      if (o_rdata_valid || o_bus_req || o_stall) events++;
    end
    n_checks++; if (events !== 0 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL late_rvalid: events=%0d rdata=%h required 0 0", events, o_rdata); end
    // reset while the request is still waiting for gnt drops req immediately
    @(negedge i_clk);
    i_mem_read = 1'b1; i_d_size = 2'b00; i_addr = 32'h0090;
    @(negedge i_clk); #1;
    n_checks++; if (o_bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_setup: got %b required 1", o_bus_req); end
    i_mem_read = 1'b0; i_rst = 1'b1;
    #1;
    n_checks++; if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_async: got %b required 0", o_bus_req); end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_byte_signed();
    test_store_half_delayed();
    test_half_extend();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
